// File: rtl/sd_arith_pkg.sv
// sd_arith_pkg: signed-digit codes, FSM state type and width helper for the digit multiplier.
package sd_arith_pkg;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} sd_state_t;
  function automatic int sd_aw(input int width, input int digits);
    return width + digits;
  endfunction
endpackage

// File: rtl/sd_digit_select.sv
// sd_digit_select: partial product d*X of a redundant vector; -1 swaps plus/minus, illegal code acts as 0.
module sd_digit_select
  import sd_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       digit,
  input  logic [WIDTH-1:0] x_plus,
  input  logic [WIDTH-1:0] x_minus,
  output logic [WIDTH-1:0] pp_plus,
  output logic [WIDTH-1:0] pp_minus,
  output logic             illegal
);
  always_comb begin
    pp_plus  = digit == SD_POS ? x_plus  : digit == SD_NEG ? x_minus : '0;
    pp_minus = digit == SD_POS ? x_minus : digit == SD_NEG ? x_plus  : '0;
    illegal  = digit == 2'b11;
  end
endmodule

// File: rtl/sd_digit_mult_acc.sv
// sd_digit_mult_acc: handshaked MSF signed-digit multiply-accumulate, acc = 2*acc + d*X.
// Defining SDVM_COLLAPSE_EN adds the registered two's-complement output result_tc.
module sd_digit_mult_acc
  import sd_arith_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        vec_in_plus,
  input  logic [WIDTH-1:0]        vec_in_minus,
  input  logic                    digit_valid,
  output logic                    digit_ready,
  input  logic [1:0]              digit_select,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [WIDTH+DIGITS-1:0] vec_out_plus,
  output logic [WIDTH+DIGITS-1:0] vec_out_minus,
  output logic                    digit_err
`ifdef SDVM_COLLAPSE_EN
  ,
  output logic [WIDTH+DIGITS:0]   result_tc
`endif
);
  localparam int AW = sd_aw(WIDTH, DIGITS);
  localparam int CW = $clog2(DIGITS + 1);
  sd_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] x_plus, x_minus, pp_plus, pp_minus;
  logic illegal, take, last;
  logic [AW-1:0] nxt_plus, nxt_minus;
  sd_digit_select #(.WIDTH(WIDTH)) u_sel (
    .digit(digit_select),
    .x_plus(x_plus),
    .x_minus(x_minus),
    .pp_plus(pp_plus),
    .pp_minus(pp_minus),
    .illegal(illegal)
  );
  assign take         = state == ACCUM && digit_valid;
  assign last         = cnt == CW'(DIGITS - 1);
  assign nxt_plus     = (vec_out_plus << 1) + AW'(pp_plus);
  assign nxt_minus    = (vec_out_minus << 1) + AW'(pp_minus);
  assign digit_ready  = state == ACCUM;
  assign result_valid = state == DONE;
  // Accumulators double as the outputs so they hold in IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      x_plus        <= '0;
      x_minus       <= '0;
      vec_out_plus  <= '0;
      vec_out_minus <= '0;
      digit_err     <= 1'b0;
`ifdef SDVM_COLLAPSE_EN
      result_tc     <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        state         <= ACCUM;
        cnt           <= '0;
        x_plus        <= vec_in_plus;
        x_minus       <= vec_in_minus;
        vec_out_plus  <= '0;
        vec_out_minus <= '0;
        digit_err     <= 1'b0;
`ifdef SDVM_COLLAPSE_EN
        result_tc     <= '0;
`endif
      end
      if (take) begin
        vec_out_plus  <= nxt_plus;
        vec_out_minus <= nxt_minus;
        digit_err     <= digit_err | illegal;
        cnt           <= cnt + 1'b1;
        if (last) state <= DONE;
`ifdef SDVM_COLLAPSE_EN
        if (last) result_tc <= {1'b0, nxt_plus} - {1'b0, nxt_minus};
`endif
      end
      if (state == DONE && result_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sd_digit_mult_acc.sv
// tb_sd_digit_mult_acc: random and directed operations checked against a closed-form product model.
module tb_sd_digit_mult_acc;
  localparam int WIDTH = 4, DIGITS = 4, AW = WIDTH + DIGITS;
  logic clk = 0, rst_n = 0, start = 0, digit_valid = 0, result_ready = 0;
  logic [WIDTH-1:0] vec_in_plus = '0, vec_in_minus = '0;
  logic [1:0] digit_select = '0;
  logic digit_ready, result_valid, digit_err;
  logic [AW-1:0] vec_out_plus, vec_out_minus;
`ifdef SDVM_COLLAPSE_EN
  logic [AW:0] result_tc;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sd_digit_mult_acc #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .vec_in_plus(vec_in_plus),
    .vec_in_minus(vec_in_minus),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .digit_select(digit_select),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .vec_out_plus(vec_out_plus),
    .vec_out_minus(vec_out_minus),
    .digit_err(digit_err)
`ifdef SDVM_COLLAPSE_EN
    ,
    .result_tc(result_tc)
`endif
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Product as a weighted sum of selected operand vectors; dv is the plain integer multiplier D.
  function automatic void model(input logic [WIDTH-1:0] xp, input logic [WIDTH-1:0] xm,
                                input logic [2*DIGITS-1:0] codes, output longint ep,
                                output longint em, output longint dv, output logic ee);
    ep = 0; em = 0; dv = 0; ee = 0;
    for (int k = 0; k < DIGITS; k++) begin
      logic [1:0] c;
      longint w;
      c = codes[2*(DIGITS-1-k) +: 2];
      w = longint'(1) << (DIGITS - 1 - k);
      if (c == 2'b10) begin ep += xp * w; em += xm * w; dv += w; end
      if (c == 2'b01) begin ep += xm * w; em += xp * w; dv -= w; end
      if (c == 2'b11) ee = 1;
    end
  endfunction
  task automatic check_idle_zero(input string tag);
    check({tag, "_plus"}, vec_out_plus, 0);
    check({tag, "_minus"}, vec_out_minus, 0);
    check({tag, "_err"}, digit_err, 0);
    check({tag, "_ready"}, digit_ready, 0);
    check({tag, "_valid"}, result_valid, 0);
  endtask
  // gap_mode: 0 back-to-back, 1 idle cycle before every digit, 2 random idles.
  task automatic run_op(input logic [WIDTH-1:0] xp, input logic [WIDTH-1:0] xm,
                        input logic [2*DIGITS-1:0] codes, input int gap_mode, input int hold);
    longint ep, em, dv;
    logic ee;
    model(xp, xm, codes, ep, em, dv, ee);
    vec_in_plus = xp; vec_in_minus = xm; start = 1;
    step();
    start = 0;
    vec_in_plus = WIDTH'($urandom); vec_in_minus = WIDTH'($urandom);
    check("start_plus_clear", vec_out_plus, 0);
    check("start_err_clear", digit_err, 0);
    check("accum_ready", digit_ready, 1);
    for (int k = 0; k < DIGITS; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        digit_valid = 0; digit_select = 2'($urandom);
        step();
      end
      check("early_valid", result_valid, 0);
      digit_valid = 1; digit_select = codes[2*(DIGITS-1-k) +: 2];
      step();
    end
    digit_valid = 0;
    check("result_valid", result_valid, 1);
    check("out_plus", vec_out_plus, ep);
    check("out_minus", vec_out_minus, em);
    check("out_value", longint'(vec_out_plus) - longint'(vec_out_minus), (longint'(xp) - longint'(xm)) * dv);
    check("out_err", digit_err, ee);
`ifdef SDVM_COLLAPSE_EN
    check("out_tc", result_tc, (AW+1)'((longint'(xp) - longint'(xm)) * dv));
`endif
    for (int j = 0; j < hold; j++) begin
      start = 1'($urandom); digit_valid = 1'($urandom); digit_select = 2'($urandom);
      step();
      check("hold_valid", result_valid, 1);
      check("hold_plus", vec_out_plus, ep);
      check("hold_minus", vec_out_minus, em);
    end
    digit_valid = 0;
    result_ready = 1; start = 1;
    step();
    result_ready = 0; start = 0;
    check("done_exit_valid", result_valid, 0);
    check("done_exit_ready", digit_ready, 0);
    check("idle_hold_plus", vec_out_plus, ep);
    check("idle_hold_err", digit_err, ee);
    step();
    check("same_cycle_start_ignored", digit_ready, 0);
  endtask
  initial begin
    step();
    check_idle_zero("reset");
    rst_n = 1;
    step();
    check_idle_zero("post_reset");
    run_op(4'b0101, 4'b0000, {2'b10, 2'b00, 2'b01, 2'b10}, 0, 0);
    run_op(4'b0000, 4'b0011, {2'b01, 2'b01, 2'b01, 2'b01}, 0, 1);
    run_op(4'b0101, 4'b0000, {2'b10, 2'b00, 2'b01, 2'b10}, 1, 0);
    run_op(4'b0101, 4'b0000, {2'b10, 2'b11, 2'b10, 2'b10}, 0, 0);
    run_op(4'b0101, 4'b0000, {2'b10, 2'b10, 2'b10, 2'b10}, 0, 10);
    vec_in_plus = 4'b1111; vec_in_minus = 4'b0001; start = 1;
    step();
    start = 0; digit_valid = 1; digit_select = 2'b10;
    step();
    step();
    digit_valid = 0;
    check("pre_reset_nonzero", vec_out_plus != 0, 1);
    rst_n = 0;
    #1;
    check_idle_zero("async_reset");
    step();
    rst_n = 1;
    digit_valid = 1; digit_select = 2'b10;
    for (int j = 0; j < 3; j++) begin
      step();
      check_idle_zero("no_start_digits");
    end
    digit_valid = 0;
    run_op(4'b1111, 4'b0001, {2'b10, 2'b01, 2'b00, 2'b10}, 0, 0);
    for (int n = 0; n < 24; n++) begin
      logic [2*DIGITS-1:0] codes;
      for (int k = 0; k < DIGITS; k++) begin
        int r;
        r = $urandom_range(0, 15);
        codes[2*k +: 2] = r == 0 ? 2'b11 : r < 6 ? 2'b10 : r < 11 ? 2'b01 : 2'b00;
      end
      run_op(WIDTH'($urandom), WIDTH'($urandom), codes, 2, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_digit_mult_acc.md
# sd_digit_mult_acc

Parametrised, registered signed-digit vector multiplier-accumulator for the Newton divider datapath. It latches a redundant operand X (plus/minus vector pair) and consumes a most-significant-first stream of DIGITS signed digits d∈{−1,0,+1}. Each cycle it forms the scaled partial product d·X and accumulates it as acc = 2·acc + d·X. After the last digit it presents the product X·D in redundant form. It replaces the combinational per-digit selector with a multi-cycle, handshaked, width- and depth-generic unit.

## Interface
- WIDTH, 4, operand vector width (each of plus/minus)
- DIGITS, 4, number of signed digits per operation (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- start  in  1  pulse; accepted only in IDLE, latches operand
- vec_in_plus  in  WIDTH  operand positive vector
- vec_in_minus  in  WIDTH  operand negative vector
- digit_valid  in  1  digit_select is valid this cycle
- digit_ready  out  1  block accepts a digit this cycle
- digit_select  in  2  digit code: 10=+1, 01=−1, 00=0, 11=illegal
- result_valid  out  1  product available
- result_ready  in  1  consumer takes product
- vec_out_plus  out  WIDTH+DIGITS  accumulated positive vector
- vec_out_minus  out  WIDTH+DIGITS  accumulated negative vector
- digit_err  out  1  sticky: an illegal digit was consumed in this operation

## Operation
- AW = WIDTH+DIGITS; value represented = plus − minus, both unsigned.
- States: IDLE, ACCUM, DONE.
- IDLE: digit_ready=0. start=1 → latch operand, clear acc_plus/acc_minus, clear digit counter and digit_err, go ACCUM.
- ACCUM: digit_ready=1. On digit_valid&digit_ready:
  - +1: acc_plus ← 2·acc_plus + Xp; acc_minus ← 2·acc_minus + Xm
  - −1: acc_plus ← 2·acc_plus + Xm; acc_minus ← 2·acc_minus + Xp (negation = plus/minus swap, exact)
  - 0: both ← 2·acc
  - 11: treated as 0, digit_err ← 1
  - counter increments; on the DIGITS-th accepted digit go DONE.
- DONE: result_valid=1, outputs stable; result_ready=1 → IDLE.
- Additions are unsigned, AW wide; no overflow is possible, since max value ≤ (2^WIDTH−1)(2^DIGITS−1).
- start outside IDLE is ignored. digit_valid outside ACCUM is ignored. Operand inputs are sampled only on accepted start.
- Reset (any time, including mid-operation): state IDLE, acc, counter, digit_err, vec_out_* all 0, digit_ready=0, result_valid=0.

## Timing
- Operand latch: 1 cycle after start. First digit can be accepted the cycle after start.
- With digit_valid held high, result_valid rises the cycle after the DIGITS-th digit edge. Latency is DIGITS+1 cycles from start to result_valid.
- Stalls: digit_valid low holds acc and counter unchanged. result_ready low holds DONE indefinitely.
- DONE→IDLE takes one cycle; start in the same cycle as result_ready is ignored. Earliest restart is the next cycle.
- vec_out_* and digit_err are registered. They hold their last value in IDLE until the next accepted start clears them.

## Configuration
- SDVM_COLLAPSE_EN defined: adds output result_tc [AW:0], registered two's-complement value acc_plus − acc_minus (sign-extended one bit). It is valid with result_valid, at the same cycle and with no extra latency. The subtractor sits in the final accumulate step.
- Undefined: no result_tc port, no subtractor. Only the redundant pair is output.

## Structure
- Shared package sd_arith_pkg: digit code constants (SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00), state enum, AW helper function.
- One sub-module, sd_digit_select: combinational WIDTH-generic selector returning the (plus, minus) partial product for a digit, including the swap and the illegal-code-as-zero rule.
- FSM, counter (clog2(DIGITS+1) bits), and accumulators stay in the top.

## Test plan
- X=(0101,0000), digits +1,0,−1,+1 back-to-back → result_valid after 5 cycles; plus=0x2D, minus=0x0A (35); result_tc=35 if enabled.
- X=(0000,0011) (−3), digits −1,−1,−1,−1 → plus=0x2D, minus=0x00 (45); digit_err=0.
- Same as first case with digit_valid low on alternate cycles → identical result; latency 9 cycles.
- Digit 11 in position 2 of +1,11,+1,+1 with X=5 → result 5·11=55 (plus=0x37, minus=0); digit_err=1, cleared on next start.
- rst_n low mid-ACCUM after 2 digits → all outputs 0, IDLE. Digits without start are ignored; a fresh operation gives the correct result.
- result_ready held low 10 cycles in DONE; start asserted meanwhile → outputs stable, start ignored; release → IDLE, next start accepted.
